// File: rtl/lsu_mem_port.sv
// Load/store unit between the execute stage and a word-addressed RAM with registered reads.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of force-aligning them.
module lsu_mem_port #(
   parameter int unsigned ADDR_W = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              ram_we,
   output logic [2:0]        ram_size,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   typedef enum logic [2:0] {IDLE, RD, LFMT, WR, MERGE, ERR} state_t;

   state_t              state_q, state_d;
   logic                we_q;
   logic [2:0]          f3_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [31:0]         wdata_q;
   logic                resp_valid_q, resp_err_q;
   logic [31:0]         resp_rdata_q;

   logic                illegal, req_err;
   logic [31:0]         load_val, merge_val;
   logic [7:0]          lane_byte;
   logic [15:0]         lane_half;
   logic                unused_addr_hi;

   assign unused_addr_hi = ^req_addr[31:ADDR_W];

   always_comb begin
      illegal = 1'b0;
      if (req_we)
         illegal = req_funct3[2] | (req_funct3[1:0] == 2'b11);
      else
         illegal = (req_funct3[1:0] == 2'b11) | (req_funct3 == 3'b110);
`ifdef LSU_MISALIGN_TRAP_EN
      req_err = illegal
              | ((req_funct3[1:0] == 2'b01) & req_addr[0])
              | ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
`else
      req_err = illegal;
`endif
   end

   // Lane selection ignores addr[0] for halves and addr[1:0] for words, which force-aligns them.
   always_comb begin
      lane_byte = ram_rdata[{addr_q[1:0], 3'b000} +: 8];
      lane_half = ram_rdata[{addr_q[1], 4'b0000} +: 16];
      case (f3_q[1:0])
         2'b00:   load_val = {{24{~f3_q[2] & lane_byte[7]}}, lane_byte};
         2'b01:   load_val = {{16{~f3_q[2] & lane_half[15]}}, lane_half};
         default: load_val = ram_rdata;
      endcase
      merge_val = ram_rdata;
      if (f3_q[1:0] == 2'b00)
         merge_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      else
         merge_val[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
   end

   always_comb begin
      state_d = IDLE;
      case (state_q)
         IDLE: begin
            state_d = IDLE;
            if (req_valid) begin
               if (req_err)
                  state_d = ERR;
               else if (req_we && (req_funct3[1:0] == 2'b10))
                  state_d = WR;
               else
                  state_d = RD;
            end
         end
         RD:      state_d = we_q ? MERGE : LFMT;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         f3_q         <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  f3_q    <= req_funct3;
                  addr_q  <= req_addr[ADDR_W-1:0];
                  wdata_q <= req_wdata;
               end
            end
            LFMT: begin
               resp_valid_q <= 1'b1;
               resp_rdata_q <= load_val;
            end
            WR, MERGE: resp_valid_q <= 1'b1;
            ERR: begin
               resp_valid_q <= 1'b1;
               resp_err_q   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Reset gates the write strobe combinationally so an in-flight WR/MERGE never commits.
   assign ram_we     = rst_n & ((state_q == WR) | (state_q == MERGE));
   assign ram_wdata  = !ram_we ? '0 : ((state_q == WR) ? wdata_q : merge_val);
   assign ram_addr   = {addr_q[ADDR_W-1:2], 2'b00};
   assign ram_size   = 3'b010;
   assign req_ready  = (state_q == IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store unit sitting between the core's execute stage and the data port of the unified word-addressed RAM. The RAM has one registered read per cycle and only whole-word writes, so this block turns RV32I loads and stores into RAM accesses. Sub-word stores become a read-modify-write. Loads are byte-lane extracted and sign/zero-extended. A simple valid/ready request channel faces the core, and a single-cycle response pulse returns to it.

## Interface
- ADDR_W, 14: byte-address width of the RAM; the word index is addr[ADDR_W-1:2]; higher request bits are ignored.
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  core presents a request.
- req_ready  out  1  high only in IDLE; a request is accepted on an edge where req_valid & req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  registered one-cycle pulse, no backpressure.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  qualified by resp_valid; request was illegal or misaligned.
- ram_we  out  1  to RAM w_enable.
- ram_size  out  3  to RAM d_size; always 3'b010.
- ram_addr  out  ADDR_W  to RAM d_addr; the latched address with [1:0] forced to 0.
- ram_wdata  out  32  to RAM d_in.
- ram_rdata  in  32  from RAM d_out_data; valid the cycle after the address is presented.

## Operation
- **FSM states:** IDLE, RD, LFMT, WR, MERGE, ERR.
- **Request latch:** on accept, the block latches we, funct3, addr[ADDR_W-1:0] and wdata.
- **Next state from IDLE:**
  - Illegal funct3 goes to ERR. Illegal means loads 011/110/111, or stores with funct3 ≠ 000/001/010.
  - Misaligned goes to ERR (see Configuration). Misaligned means halfword with addr[0]=1, or word with addr[1:0]≠0.
  - A load goes to RD.
  - SW goes to WR.
  - SB/SH go to RD.
- **RD:**
  - Drives ram_addr and ram_we=0.
  - Next state is LFMT for a load, MERGE for a store.
- **LFMT:**
  - Extracts from ram_rdata, little-endian. The byte is word[8*a+7:8*a] with a=addr[1:0]. The half is word[16*h+15:16*h] with h=addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Registers the result into resp_rdata, sets resp_valid, and returns to IDLE.
- **MERGE:**
  - Drives ram_we=1 and ram_wdata = ram_rdata with the addressed lane replaced.
  - SB replaces byte lane a with wdata[7:0]; SH replaces half lane h with wdata[15:0].
  - Sets resp_valid and returns to IDLE.
- **WR:** drives ram_we=1 and ram_wdata=wdata, sets resp_valid, and returns to IDLE.
- **ERR:** no RAM access; sets resp_valid with resp_err=1, resp_rdata=0, and returns to IDLE.
- **Idle outputs:** ram_we=0 in IDLE, RD, LFMT and ERR. ram_wdata=0 whenever ram_we=0.
- **Reset:** while rst_n=0, ram_we is forced to 0 combinationally, so no RAM write occurs at an edge where reset is asserted, even in WR or MERGE.
- **Reset values:** state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, latched fields 0; therefore req_ready=1 after reset.
- **Reset mid-operation:** the operation is abandoned without a response and without a write.

## Timing
- Request accepted at edge E0.
- **LW/LB/LH/LBU/LHU:**
  - RD during E0→E1; the RAM samples the address at E1.
  - LFMT during E1→E2.
  - resp_valid high during E2→E3, so the response is visible 2 cycles after the cycle following accept.
- **SW:** write at E1; resp_valid high during E1→E2.
- **SB/SH:**
  - Read at E1, merge-write at E2.
  - resp_valid high during E2→E3.
- **Error:** resp_valid high during E1→E2.
- **Back-to-back requests:** the FSM is in IDLE during the resp_valid cycle, so req_ready=1 and back-to-back requests are accepted with no bubble beyond the FSM latency.
- **Load after store:** a load to the word just stored reads the new data, because the write edge precedes the next RD edge.

## Configuration
- **With LSU_MISALIGN_TRAP_EN defined:** misaligned halfword/word accesses go to ERR (resp_err=1, no RAM access).
- **Without it:**
  - Misaligned accesses are force-aligned: the halfword uses h=addr[1] with addr[0] ignored, and the word ignores addr[1:0].
  - These accesses proceed normally with resp_err=0.
- Illegal funct3 errors in both builds.

## Test plan
- **Word round trip:** SW addr 0x100 wdata 0xDEADBEEF, then LW 0x100 → resp_rdata 0xDEADBEEF, resp_err=0, load resp_valid 3 edges after accept.
- **Byte RMW and sign extension:**
  - Preload 0x11223344 at 0x200, then SB addr 0x202 wdata 0xAB → word reads 0x11AB3344.
  - LB 0x202 → 0xFFFFFFAB; LBU 0x202 → 0x000000AB.
- **Halfword RMW and sign extension:**
  - SH addr 0x206 wdata 0x8001 onto 0x00000000 → word 0x80010000.
  - LH 0x206 → 0xFFFF8001; LHU 0x206 → 0x00008001.
- **Misalignment, macro defined:** LW addr 0x101 → resp_err=1, resp_rdata=0, no ram_we pulse, memory unchanged.
- **Misalignment, macro undefined:** the same LW returns word 0x100.
- **Illegal funct3:** load with funct3=011 → resp_err=1 with no RAM access.
- **Reset in MERGE:** SB to 0x300 with rst_n driven low during the MERGE cycle → no write (word unchanged), no resp_valid, req_ready=1 after reset.
- **Back-to-back accepts:** SW then LW accepted in consecutive IDLE cycles → req_ready low while busy, both responses in order, no lost request.
